sseg_decoder: RTL and testbench
===============================

# sseg_decoder

Receive-side counterpart of the `sseg` multiplexed display driver. It samples the time-multiplexed active-low `an`/`sseg` bus, waits for each digit slot to be stable, and decodes the segment patterns back into hex nibbles. It reassembles one full 4-digit scan into a 16-bit word plus decimal points. It sits on display loopback paths and in self-check logic that confirms what the driver is actually showing.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: number of consecutive identical samples of `{an,sseg}` required before a slot is accepted. Legal range is 2..255.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sseg`  in  8  segment bus, active-low. Bit 0 = a, bits 1..6 = b..g, bit 7 = dp.
- `an`  in  8  anode bus, active-low. Bits 3:0 select digits 0..3; bits 7:4 must stay high.
- `digits`  out  16  last complete frame. `digits[4i+3:4i]` is digit i.
- `dp`  out  4  last complete frame decimal points, active-high. `dp[i]` = NOT `sseg[7]` for digit i.
- `valid`  out  1  one-cycle pulse when `digits`/`dp` update.
- `err`  out  1  one-cycle pulse on a protocol or decode error.

## Operation
- **Stability tracker**
  - Register `prev` holds the last sample of `{an,sseg}`.
  - If the current sample equals `prev`, counter `cnt` increments and saturates at `STABLE_CYCLES-1`. Otherwise `cnt` clears to 0.
  - The "stable cycle" is the cycle in which `cnt` first reaches `STABLE_CYCLES-1`. That is the `STABLE_CYCLES`-th identical sample, and there is exactly one stable cycle per dwell.
- **Stable-cycle classification**
  - Blank: `an` = 8'hFF. Ignored with no state change.
  - Legal slot: `an[7:4]` = 4'hF and `an[3:0]` has exactly one zero bit.
  - Anything else is an error.
- **Segment decode**
  - Invert `sseg[6:0]`, then match the active-high gfedcba pattern: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Any other pattern is an error.
- **FSM states**
  - **HUNT** (reset state): a legal slot for digit 0 with a good pattern stores nibble and dp into shadow slot 0, sets `mask`=4'b0001, and moves to COLLECT. Legal slots for digits 1..3 are discarded.
  - **COLLECT**: a legal slot for digit i with a good pattern stores into shadow slot i and sets `mask[i]`. A repeated slot overwrites its shadow value. When `mask` becomes 4'hF, copy the shadow registers to `digits`/`dp`, pulse `valid`, clear `mask`, and go to HUNT.
- **Errors**
  - Any error on a stable cycle, in either state, pulses `err`, clears `mask`, and forces HUNT.
  - Outputs `digits`/`dp` are never modified by an error.
- **Boundary cases**
  - Error and completion cannot coincide, since only one slot is classified per cycle.
  - A bus change during the stable cycle restarts counting on the next cycle.
  - Glitches shorter than `STABLE_CYCLES` cycles are invisible.
  - Reset mid-frame discards the partial frame.

## Timing
- **Reset values:**
  - `digits`=16'h0000, `dp`=4'h0, `valid`=0, `err`=0.
  - `prev`=16'hFFFF, `cnt`=0, `mask`=0, state HUNT.
- **Latency:** if `{an,sseg}` first takes a new value in cycle t and holds it, the stable cycle is t+`STABLE_CYCLES`-1.
  - `digits`/`dp`/`valid` (on the digit completing a frame) are visible in cycle t+`STABLE_CYCLES`.
  - `err` for that slot is also visible in cycle t+`STABLE_CYCLES`.
- **Handshake:** there is none. `valid` is a single-cycle pulse with no backpressure, and `digits`/`dp` hold until the next `valid`.
- **Throughput:** at most one frame per 4 dwells.

## Configuration
- `SSEG_DEC_SYNC_EN`
  - **Defined:** `an` and `sseg` pass through a two-flop synchronizer, reset to all ones, before the stability tracker. All latencies above grow by 2 cycles. Use this when the bus comes from external pins.
  - **Undefined:** inputs feed the tracker directly, with latency exactly as stated above.

## Test plan
- **Loopback:** `sseg` driver with `MUX_DIV_BITS`=8 and `digits`=16'h8320 drives the decoder (`STABLE_CYCLES`=4). Required: `valid` pulses once per scan with `digits`=16'h8320, `dp`=0, and `err` never asserts.
- **Value change:** the driver switches to 16'hABCD, then 16'h8888. Required: at most one `valid` carries a mixed value, after which every `valid` carries exactly 16'hABCD, then exactly 16'h8888.
- **Glitch rejection:** direct stimulus holds digit 0 = "5" for 3 cycles, then a legal frame 1,2,3,4 (digit 0 = "1") with 4-cycle dwells. Required: one `valid` with `digits`=16'h4321 and `err`=0.
- **Bad pattern:** digit 2 is held at `sseg`=8'hFF (segments all off) with `an`=8'hFB for 4 cycles. Required: `err` pulses 4 cycles after the dwell starts, the frame is dropped, `digits` is unchanged, and the next complete frame decodes correctly.
- **Bad anode:** `an`=8'hFC is held for 4 cycles. Required: one `err` pulse. `an`=8'hFF held for 10 cycles produces no `err` and no `valid`.
- **Reset mid-frame:** `rst_n` is pulled low after digits 0 and 1 are captured. Required: all outputs are 0 immediately. After release, digits 2 and 3 alone produce no `valid`.

Source files
------------

// File: rtl/sseg_decoder.sv
// Decodes a time-multiplexed, active-low 7-segment/anode bus back into a 4-digit hex frame.
// Define SSEG_DEC_SYNC_EN to add a two-flop input synchronizer (reset to all ones) ahead of the tracker.
module sseg_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sseg,
  input  logic [7:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  logic [15:0] bus;

`ifdef SSEG_DEC_SYNC_EN
  logic [15:0] sync_q1;
  logic [15:0] sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= {an, sseg};
      sync_q2 <= sync_q1;
    end
  end

  assign bus = sync_q2;
`else
  assign bus = {an, sseg};
`endif

  logic [15:0] prev;
  logic [7:0]  cnt;
  logic        same;
  logic        stable;

  // stable fires only on the transition into saturation, so once per dwell
  assign same   = (bus == prev);
  assign stable = same && (cnt == CNT_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '1;
      cnt  <= '0;
    end else begin
      prev <= bus;
      if (!same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
    end
  end

  logic [7:0] an_s;
  logic [7:0] sg_s;
  logic [6:0] seg_on;
  logic       blank;
  logic       slot_ok;
  logic [1:0] slot;
  logic       pat_ok;
  logic [3:0] nib;

  assign an_s   = bus[15:8];
  assign sg_s   = bus[7:0];
  assign seg_on = ~sg_s[6:0];
  assign blank  = (an_s == 8'hFF);

  always_comb begin
    slot    = 2'd0;
    slot_ok = 1'b0;
    if (an_s[7:4] == 4'hF) begin
      case (an_s[3:0])
        4'hE: begin slot = 2'd0; slot_ok = 1'b1; end
        4'hD: begin slot = 2'd1; slot_ok = 1'b1; end
        4'hB: begin slot = 2'd2; slot_ok = 1'b1; end
        4'h7: begin slot = 2'd3; slot_ok = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    pat_ok = 1'b1;
    nib    = 4'h0;
    case (seg_on)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: pat_ok = 1'b0;
    endcase
  end

  state_t      state;
  logic [3:0]  mask;
  logic [15:0] shadow;
  logic [3:0]  shadow_dp;
  logic [15:0] merged;
  logic [3:0]  merged_dp;
  logic [3:0]  slot_bit;
  logic [3:0]  mask_next;
  logic        good;

  assign good      = slot_ok && pat_ok;
  assign slot_bit  = 4'b0001 << slot;
  assign mask_next = mask | slot_bit;

  // shadow frame with the current slot already written, so completion can copy it in one step
  always_comb begin
    merged                  = shadow;
    merged_dp               = shadow_dp;
    merged[{slot, 2'b00} +: 4] = nib;
    merged_dp[slot]         = ~sg_s[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      mask      <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      digits    <= '0;
      dp        <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (stable && !blank) begin
        if (!good) begin
          err   <= 1'b1;
          mask  <= '0;
          state <= HUNT;
        end else begin
          case (state)
            HUNT: begin
              if (slot == 2'd0) begin
                shadow    <= merged;
                shadow_dp <= merged_dp;
                mask      <= 4'b0001;
                state     <= COLLECT;
              end
            end
            COLLECT: begin
              shadow    <= merged;
              shadow_dp <= merged_dp;
              if (mask_next == 4'hF) begin
                digits <= merged;
                dp     <= merged_dp;
                valid  <= 1'b1;
                mask   <= '0;
                state  <= HUNT;
              end else begin
                mask <= mask_next;
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_decoder.sv
// Bench for sseg_decoder: directed dwell table, reset-mid-frame sequence, and random scans
// compared cycle by cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_sseg_decoder;

  localparam int S = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  sseg  = 8'hFF;
  logic [7:0]  an    = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        valid;
  logic        err;

  sseg_decoder #(.STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sseg  (sseg),
    .an    (an),
    .digits(digits),
    .dp    (dp),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int seen_valid;
  int seen_err;
  int cyc = 0;

  logic [15:0] m_last;
  int          m_run;
  bit          m_collect;
  logic [3:0]  m_mask;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_shdp;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  bit          m_valid;
  bit          m_err;
`ifdef SSEG_DEC_SYNC_EN
  logic [15:0] m_pipe [2];
`endif

  function automatic logic [7:0] seg(input int n, input bit d);
    return ~{d, GLYPH[n]};
  endfunction

  function void model_reset();
    m_last    = 16'hFFFF;
    m_run     = 1;
    m_collect = 0;
    m_mask    = 4'h0;
    m_shdp    = 4'h0;
    m_digits  = 16'h0000;
    m_dp      = 4'h0;
    m_valid   = 0;
    m_err     = 0;
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
`ifdef SSEG_DEC_SYNC_EN
    m_pipe[0] = 16'hFFFF;
    m_pipe[1] = 16'hFFFF;
`endif
  endfunction

  // one accepted dwell: classify the anode, look the glyph up, update the frame
  function void model_event(input logic [15:0] v);
    logic [7:0] a;
    logic [7:0] s;
    int digit;
    int value;
    a = v[15:8];
    s = v[7:0];
    digit = -1;
    value = -1;
    if (a == 8'hFF) return;
    if (a[7:4] == 4'hF && $countones(a[3:0]) == 3)
      for (int i = 0; i < 4; i++) if (a[i] == 1'b0) digit = i;
    for (int g = 0; g < 16; g++) if (GLYPH[g] == ~s[6:0]) value = g;
    if (digit < 0 || value < 0) begin
      m_err     = 1;
      m_mask    = 4'h0;
      m_collect = 0;
      return;
    end
    if (!m_collect && digit != 0) return;
    m_nib[digit]  = 4'(value);
    m_shdp[digit] = ~s[7];
    m_mask[digit] = 1'b1;
    m_collect     = 1;
    if (m_mask == 4'hF) begin
      for (int i = 0; i < 4; i++) m_digits[4*i +: 4] = m_nib[i];
      m_dp      = m_shdp;
      m_valid   = 1;
      m_mask    = 4'h0;
      m_collect = 0;
    end
  endfunction

  function void model_sample(input logic [15:0] v);
    logic [15:0] x;
`ifdef SSEG_DEC_SYNC_EN
    x = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = v;
`else
    x = v;
`endif
    if (x == m_last) begin
      if (m_run <= S) begin
        m_run++;
        if (m_run == S) model_event(x);
      end
    end else begin
      m_run = 1;
    end
    m_last = x;
  endfunction

  task automatic step(input logic [7:0] a, input logic [7:0] s);
    an   = a;
    sseg = s;
    @(posedge clk);
    m_valid = 0;
    m_err   = 0;
    model_sample({a, s});
    @(negedge clk);
    cyc++;
    tests++;
    if ({valid, err, dp, digits} !== {m_valid, m_err, m_dp, m_digits}) begin
      fails++;
      $display("[TB] FAIL model cycle %0d: got v=%b e=%b dp=%h d=%h, want v=%b e=%b dp=%h d=%h",
               cyc, valid, err, dp, digits, m_valid, m_err, m_dp, m_digits);
    end
    if (valid) seen_valid++;
    if (err) seen_err++;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] s, input int len);
    seen_valid = 0;
    seen_err   = 0;
    repeat (len) step(a, s);
  endtask

  task automatic checkOutput(input string name, input int ev, input int ee,
                             input logic [15:0] ed, input logic [3:0] edp);
    tests++;
    if (seen_valid != ev || seen_err != ee) begin
      fails++;
      $display("[TB] FAIL %s pulses: got valid=%0d err=%0d, want valid=%0d err=%0d",
               name, seen_valid, seen_err, ev, ee);
    end
    tests++;
    if (digits !== ed || dp !== edp) begin
      fails++;
      $display("[TB] FAIL %s data: got digits=%h dp=%h, want digits=%h dp=%h",
               name, digits, dp, ed, edp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  s;
    int          len;
    int          ev;
    int          ee;
    logic [15:0] ed;
    logic [3:0]  edp;
  } row_t;

  row_t rows [21];

  initial begin
    logic [7:0] la;
    logic [7:0] ls;
    int cur_dig;

    rows[0]  = '{8'hFE, seg(5, 0), 3,  0, 0, 16'h0000, 4'h0};
    rows[1]  = '{8'hFE, seg(1, 0), 4,  0, 0, 16'h0000, 4'h0};
    rows[2]  = '{8'hFD, seg(2, 0), 4,  0, 0, 16'h0000, 4'h0};
    rows[3]  = '{8'hFB, seg(3, 0), 4,  0, 0, 16'h0000, 4'h0};
    rows[4]  = '{8'hF7, seg(4, 0), 4,  1, 0, 16'h4321, 4'h0};
    rows[5]  = '{8'hFE, seg(10, 0), 4, 0, 0, 16'h4321, 4'h0};
    rows[6]  = '{8'hFD, seg(11, 0), 4, 0, 0, 16'h4321, 4'h0};
    rows[7]  = '{8'hFB, 8'hFF, 4,      0, 1, 16'h4321, 4'h0};
    rows[8]  = '{8'hF7, seg(12, 0), 4, 0, 0, 16'h4321, 4'h0};
    rows[9]  = '{8'hFE, seg(9, 0), 4,  0, 0, 16'h4321, 4'h0};
    rows[10] = '{8'hFD, seg(8, 1), 4,  0, 0, 16'h4321, 4'h0};
    rows[11] = '{8'hFB, seg(7, 0), 4,  0, 0, 16'h4321, 4'h0};
    rows[12] = '{8'hF7, seg(6, 0), 4,  1, 0, 16'h6789, 4'h2};
    rows[13] = '{8'hFC, seg(1, 0), 4,  0, 1, 16'h6789, 4'h2};
    rows[14] = '{8'hFF, 8'hFF, 10,     0, 0, 16'h6789, 4'h2};
    rows[15] = '{8'h7E, seg(1, 0), 4,  0, 1, 16'h6789, 4'h2};
    rows[16] = '{8'hFE, seg(1, 0), 4,  0, 0, 16'h6789, 4'h2};
    rows[17] = '{8'hFD, seg(2, 0), 4,  0, 0, 16'h6789, 4'h2};
    rows[18] = '{8'hFE, seg(3, 0), 4,  0, 0, 16'h6789, 4'h2};
    rows[19] = '{8'hFB, seg(4, 0), 4,  0, 0, 16'h6789, 4'h2};
    rows[20] = '{8'hF7, seg(5, 0), 4,  1, 0, 16'h5423, 4'h0};

    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({digits, dp, valid, err} !== 22'h0) begin
      fails++;
      $display("[TB] FAIL reset state: got digits=%h dp=%h valid=%b err=%b, want all zero",
               digits, dp, valid, err);
    end
    rst_n = 1'b1;

    for (int r = 0; r < 21; r++) begin
      applyStimulus(rows[r].a, rows[r].s, rows[r].len);
      checkOutput($sformatf("row%0d", r), rows[r].ev, rows[r].ee, rows[r].ed, rows[r].edp);
    end

    applyStimulus(8'hFE, seg(10, 0), 4);
    applyStimulus(8'hFD, seg(11, 0), 4);
    an    = 8'hFF;
    sseg  = 8'hFF;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({digits, dp, valid, err} !== 22'h0) begin
      fails++;
      $display("[TB] FAIL mid-frame reset: got digits=%h dp=%h valid=%b err=%b, want all zero",
               digits, dp, valid, err);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'hFB, seg(12, 0), 4);
    checkOutput("after-reset d2", 0, 0, 16'h0000, 4'h0);
    applyStimulus(8'hF7, seg(13, 0), 4);
    checkOutput("after-reset d3", 0, 0, 16'h0000, 4'h0);

    la = 8'hF7;
    ls = seg(13, 0);
    cur_dig = 3;
    for (int k = 0; k < 400; k++) begin
      logic [7:0] a;
      logic [7:0] s;
      int r;
      int len;
      do begin
        r = int'($urandom_range(99));
        if (r < 70) cur_dig = (cur_dig + 1) % 4;
        else if (r < 85) cur_dig = int'($urandom_range(3));
        a = 8'hFF;
        a[cur_dig] = 1'b0;
        s = seg(int'($urandom_range(15)), bit'($urandom_range(1)));
        if (r >= 85 && r < 90) a = 8'hFF;
        else if (r >= 90 && r < 95) a = 8'($urandom);
        else if (r >= 95) s = 8'($urandom);
      end while ({a, s} == {la, ls});
      len = (r < 80) ? int'($urandom_range(S, S + 3)) : int'($urandom_range(1, S + 3));
      applyStimulus(a, s, len);
      la = a;
      ls = s;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
